// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-master round-robin arbiter in front of a single-port RAM with
//             a combinational read port. Each transaction takes IDLE -> ACCESS
//             -> DONE. The RAM is driven for exactly one cycle, and the granted
//             master receives a one-cycle ack in DONE.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             m0_* / m1_*          - master request/response (m0 = ifetch,
//                                    m1 = data load/store)
//             ram_en/rw/addr/din   - registered RAM control and write data
//             ram_dout             - RAM combinational read data
//             busy                 - high whenever the FSM is not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_grant;   // master granted most recently (1 = m1)
    logic   r_grant;        // master owning the transaction in flight

    // m1 wins when it is the only requester, or when both request and m0 was
    // the last one served.
    logic   w_pick_m1;
    assign w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // m0 wins the first contended arbitration
            r_grant      <= 1'b0;
            ram_en       <= 1'b0;
            ram_rw       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            busy         <= 1'b0;
        end else begin
            // Acks are single-cycle pulses raised only on the ACCESS->DONE edge.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        r_state      <= ACCESS;
                        busy         <= 1'b1;
                        r_grant      <= w_pick_m1;
                        r_last_grant <= w_pick_m1;
                        ram_en       <= 1'b1;
                        ram_rw       <= w_pick_m1 ? m1_rw    : m0_rw;
                        ram_addr     <= w_pick_m1 ? m1_addr  : m0_addr;
                        ram_din      <= w_pick_m1 ? m1_wdata : m0_wdata;
                    end
                end

                ACCESS: begin
                    r_state <= DONE;
                    ram_en  <= 1'b0;
                    // ram_dout is only meaningful on a read; a write leaves
                    // rdata untouched while the RAM commits on this same edge.
                    if (!ram_rw) begin
                        if (r_grant) begin
                            m1_rdata <= ram_dout;
                        end else begin
                            m0_rdata <= ram_dout;
                        end
                    end
                    if (r_grant) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    ram_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter. A small word-addressed RAM
//             model sits behind the DUT; expected transactions are queued as
//             they are driven and retired when an ack appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              m0_req, m0_rw, m1_req, m1_rw;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              ram_en, ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;
    logic              busy;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_rw    (m0_rw),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_rw    (m1_rw),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .ram_en   (ram_en),
        .ram_rw   (ram_rw),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model: 64 words, byte address bits [7:2] ----------
    logic [DATA_W-1:0] mem [64];
    logic              mem_init;

    assign ram_dout = (ram_en && !ram_rw) ? mem[ram_addr[7:2]] : 'x;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[6'h10] <= 32'hDEADBEEF;
            mem[6'h3F] <= 32'hCAFEF00D;
        end else if (ram_en && ram_rw) begin
            mem[ram_addr[7:2]] <= ram_din;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          m;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor on the falling edge: RAM-side contents and ack/rdata contents.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ack && m1_ack) begin
                n_cmp++;
                n_bad++;
                $display("FAIL both_acks: got m0_ack=1 m1_ack=1, required at most one");
            end
            if (ram_en && sb.size() > 0) begin
                check("ram_addr", ram_addr, sb[0].addr);
                check("ram_rw", {31'b0, ram_rw}, {31'b0, sb[0].rw});
                if (sb[0].rw) check("ram_din", ram_din, sb[0].wdata);
            end
            if (m0_ack || m1_ack) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_ack: got m0_ack=%b m1_ack=%b, required no ack", m0_ack, m1_ack);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    check("ack_master", {31'b0, m1_ack}, {31'b0, e.m});
                    check("rdata", e.m ? m1_rdata : m0_rdata, e.exp_rd);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive(input bit m, input bit req, input bit rw,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req = req; m1_rw = rw; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_rw = rw; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // One transaction from an idle FSM; checks the 2-cycle latency. With
    // drop_early, req is withdrawn and addr/wdata scrambled right after grant.
    task automatic run_txn(input vec_t v, input bit drop_early);
        int n;
        bit got;
        sb.push_back(v);
        drive(v.m, 1'b1, v.rw, v.addr, v.wdata);
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (drop_early && n == 1) drive(v.m, 1'b0, ~v.rw, v.addr ^ 32'h4, ~v.wdata);
            if (m0_ack || m1_ack) got = 1;
        end
        check("ack_latency", n, got ? 2 : -1);
        if (!got) sb.delete();
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk); #1;
        check("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    // Both masters hold requests; acks must alternate starting with m0,
    // one every 3 cycles.
    task automatic run_contention(input int npairs);
        int n;
        int ack_at[$];
        for (int i = 0; i < npairs; i++) begin
            sb.push_back('{1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF});
            sb.push_back('{1'b1, 1'b0, 32'h80, 32'h0, 32'h12345678});
        end
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        n = 0;
        while (ack_at.size() < 2 * npairs && n < 10 * npairs) begin
            @(posedge clk); #1;
            n++;
            if (m0_ack || m1_ack) ack_at.push_back(n);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk); #1;
        check("contend_ack_count", ack_at.size(), 2 * npairs);
        foreach (ack_at[k]) check("contend_ack_cycle", ack_at[k], 2 + 3 * k);
        sb.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ram_en"},   {31'b0, ram_en}, 32'd0);
        check({tag, "_busy"},     {31'b0, busy},   32'd0);
        check({tag, "_m0_ack"},   {31'b0, m0_ack}, 32'd0);
        check({tag, "_m1_ack"},   {31'b0, m1_ack}, 32'd0);
        check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b1, 32'h80, 32'h12345678, 32'h00000000};
        tbl[2] = '{1'b1, 1'b0, 32'h80, 32'h0,        32'h12345678};
        tbl[3] = '{1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'hA5A5A5A5};
        tbl[5] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
        tbl[6] = '{1'b0, 1'b0, 32'hFC, 32'h0,        32'hCAFEF00D};
        tbl[7] = '{1'b1, 1'b1, 32'h00, 32'hFFFFFFFF, 32'hDEADBEEF};
        tbl[8] = '{1'b1, 1'b0, 32'h00, 32'h0,        32'hFFFFFFFF};
        tbl[9] = '{1'b0, 1'b0, 32'h80, 32'h0,        32'h12345678};

        m0_req = 0; m0_rw = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_rw = 0; m1_addr = '0; m1_wdata = '0;
        mem_init = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst = 1'b0;
        check_reset_state("reset");
        check("reset_ram_addr", ram_addr, 32'd0);
        check("reset_ram_din", ram_din, 32'd0);
        check("reset_ram_rw", {31'b0, ram_rw}, 32'd0);

        // Table of single transactions.
        for (int i = 0; i < 10; i++) run_txn(tbl[i], 1'b0);

        // m1 withdraws req (and scrambles its inputs) right after grant.
        run_txn('{1'b1, 1'b0, 32'h44, 32'h0, 32'hA5A5A5A5}, 1'b1);

        // Idle hold: nothing moves for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_ram_en", {31'b0, ram_en}, 32'd0);
            check("idle_busy", {31'b0, busy}, 32'd0);
            check("idle_m0_rdata", m0_rdata, 32'h12345678);
            check("idle_m1_rdata", m1_rdata, 32'hA5A5A5A5);
        end

        // Contention straight out of reset, then continued alternation.
        apply_reset();
        check_reset_state("reset2");
        run_contention(3);

        // Leave last_grant pointing at m0, then reset in the middle of an m0 read.
        run_txn('{1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF}, 1'b0);
        sb.push_back('{1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF});
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(posedge clk); #1;
        check("midrst_access_en", {31'b0, ram_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
        m0_req = 1'b0;
        check_reset_state("midrst");
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_ack", {31'b0, m0_ack | m1_ack}, 32'd0);
        end
        run_contention(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
